// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory, and hands words to the decoder over valid/ready.
// Fetched words are held in an output register backed by one skid register.
// Redirects from the branch/jump logic flush both registers and restart
// fetching at the selected target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  input  logic        redirect,
  input  logic [1:0]  pc_mux_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next;
  logic [31:0] instr_next, instr_pc_next;
  logic [31:0] skid_data, skid_data_next;
  logic [31:0] skid_pc, skid_pc_next;
  logic [31:0] target;
  logic        xfer;
  logic        redir;

  // A word leaves the output register whenever the decoder takes it.
  assign xfer = instr_valid & decode_ready;
  // Redirects are honoured only with a real source selected and once out of IDLE.
  assign redir = redirect & (pc_mux_sel != 2'b00) & (state != IDLE);

  // The skid register is occupied exactly while in HOLD, so memory is idle then.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // Redirect target selection, same encoding the decoder drives.
  always_comb begin
    target = pc;
    case (pc_mux_sel)
      2'b01:   target = branch_target;
      2'b10:   target = jump_target;
      2'b11:   target = reg_target;
      default: target = pc;
    endcase
  end

  // Next-state, PC and buffer updates; redirect overrides everything else.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    valid_next     = instr_valid;
    instr_next     = instruction;
    instr_pc_next  = instr_pc;
    skid_data_next = skid_data;
    skid_pc_next   = skid_pc;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          pc_next = pc + 32'd4;
          if (!instr_valid || xfer) begin
            instr_next    = imem_rdata;
            instr_pc_next = pc;
            valid_next    = 1'b1;
          end else begin
            skid_data_next = imem_rdata;
            skid_pc_next   = pc;
            state_next     = HOLD;
          end
        end else if (xfer) begin
          valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (xfer) begin
          instr_next    = skid_data;
          instr_pc_next = skid_pc;
          state_next    = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redir) begin
      pc_next    = {target[31:2], 2'b00};
      valid_next = 1'b0;
      state_next = FETCH;
    end
  end

  // State, PC and buffer registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      instr_pc    <= 32'h0;
      skid_data   <= 32'h0;
      skid_pc     <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_valid <= valid_next;
      instruction <= instr_next;
      instr_pc    <= instr_pc_next;
      skid_data   <= skid_data_next;
      skid_pc     <= skid_pc_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized
// traffic, checked by a program-order reference model and a scoreboard.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect;
  logic [1:0]  pc_mux_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] reg_target;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       q[$];
  logic [31:0] m_next_pc;
  bit          m_idle;
  logic [31:0] w_seen[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .decode_ready(decode_ready),
    .redirect(redirect), .pc_mux_sel(pc_mux_sel),
    .branch_target(branch_target), .jump_target(jump_target), .reg_target(reg_target)
  );

  // Second instance only exercises PC wrap-around from a high reset PC.
  assign w_rdata = w_addr ^ 32'hA5A5_A5A5;
  instr_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instruction(w_instr), .instr_pc(w_pc),
    .decode_ready(1'b1),
    .redirect(1'b0), .pc_mux_sel(2'b00),
    .branch_target(32'h0), .jump_target(32'h0), .reg_target(32'h0)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus, applied just after the rising edge.
  task automatic cyc(input logic rdy, input logic ack, input logic rd, input logic [1:0] sel,
                     input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] rt);
    @(posedge clk);
    #1;
    decode_ready  = rdy;
    imem_ack      = ack && imem_req;
    imem_rdata    = mem(imem_addr);
    redirect      = rd;
    pc_mux_sel    = sel;
    branch_target = bt;
    jump_target   = jt;
    reg_target    = rt;
  endtask

  task automatic run(input logic rdy, input logic ack, input int n);
    for (int i = 0; i < n; i++) cyc(rdy, ack, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
  endtask

  // Reference model: words come out in program order from the current fetch
  // PC; an effective redirect discards everything not yet consumed.
  initial begin
    m_next_pc = RST_PC;
    m_idle    = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        q.delete();
        m_next_pc = RST_PC;
        m_idle    = 1'b1;
      end else if (m_idle) begin
        chk("idle_no_req", {31'h0, imem_req}, 32'h0);
        m_idle = 1'b0;
      end else begin
        if (imem_req) chk("imem_addr", imem_addr, m_next_pc);
        if (redirect && pc_mux_sel != 2'b00) begin
          q.delete();
          case (pc_mux_sel)
            2'b01:   m_next_pc = branch_target & ~32'h3;
            2'b10:   m_next_pc = jump_target & ~32'h3;
            default: m_next_pc = reg_target & ~32'h3;
          endcase
        end else if (imem_req && imem_ack) begin
          q.push_back('{pc: m_next_pc, ins: mem(m_next_pc)});
          m_next_pc = m_next_pc + 32'd4;
          if (q.size() > 2) chk("buffer_depth", q.size(), 2);
        end
      end
    end
  end

  // Monitor: every transfer to the decoder is compared with the scoreboard.
  initial begin
    item_t       it;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [31:0] prev_i = 32'h0;
    logic [31:0] prev_p = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (instr_valid && prev_v && !prev_r) begin
          chk("stall_instruction", instruction, prev_i);
          chk("stall_instr_pc", instr_pc, prev_p);
        end
        if (instr_valid && decode_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got pc %h, expected no word", instr_pc);
          end else begin
            it = q.pop_front();
            chk("instr_pc", instr_pc, it.pc);
            chk("instruction", instruction, it.ins);
          end
        end
        prev_v = instr_valid;
        prev_r = decode_ready;
        prev_i = instruction;
        prev_p = instr_pc;
      end
      if (rst_n && w_valid && w_seen.size() < 3) begin
        w_seen.push_back(w_pc);
        chk("wrap_instruction", w_instr, mem(w_pc));
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [31:0] t0, t1, t2;
    rst_n = 1'b0; decode_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; pc_mux_sel = 2'b00;
    branch_target = 32'h0; jump_target = 32'h0; reg_target = 32'h0;
    #2;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming: one word per cycle once the pipe is primed.
    run(1'b1, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("stream_valid", {31'h0, instr_valid}, 32'h1);
    end

    // Decoder stall: second word goes to the skid, fetch stops.
    run(1'b0, 1'b1, 2);
    @(negedge clk);
    chk("hold_no_req", {31'h0, imem_req}, 32'h0);
    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
    run(1'b0, 1'b1, 2);
    run(1'b1, 1'b1, 4);

    // Branch redirect coinciding with an ack.
    cyc(1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_0103, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("branch_addr", imem_addr, 32'h0000_0100);
    chk("branch_flush", {31'h0, instr_valid}, 32'h0);
    run(1'b1, 1'b1, 6);

    // Register-jump redirect while the skid is full.
    run(1'b0, 1'b1, 3);
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 32'h0, 32'h0, 32'h0000_0040);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("reg_flush", {31'h0, instr_valid}, 32'h0);
    chk("reg_addr", imem_addr, 32'h0000_0040);
    run(1'b1, 1'b1, 6);

    // Redirect strobe with no source selected is ignored.
    run(1'b0, 1'b1, 3);
    cyc(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0000_0200);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("nosel_valid", {31'h0, instr_valid}, 32'h1);
    chk("nosel_no_req", {31'h0, imem_req}, 32'h0);
    run(1'b1, 1'b1, 6);

    // Randomized traffic, including redirects near the top of memory.
    for (int i = 0; i < 3000; i++) begin
      t0 = $urandom;
      t1 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      t2 = $urandom & 32'h0000_0FFF;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), t0, t1, t2);
    end

    // Asynchronous reset with output and skid both full.
    run(1'b0, 1'b1, 4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_imem_req", {31'h0, imem_req}, 32'h0);
    chk("async_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_instruction", instruction, 32'h0);
    chk("async_instr_pc", instr_pc, 32'h0);
    chk("async_imem_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1;
    // A redirect during the IDLE cycle after release must be ignored.
    rst_n = 1'b1; decode_ready = 1'b1; imem_ack = 1'b0;
    redirect = 1'b1; pc_mux_sel = 2'b01; branch_target = 32'h0000_0500;
    run(1'b1, 1'b1, 10);

    // Drain what is still buffered.
    run(1'b1, 1'b0, 4);
    @(negedge clk);
    #2;
    chk("drain_empty", q.size(), 32'h0);

    chk("wrap_count", w_seen.size(), 32'd3);
    if (w_seen.size() == 3) begin
      chk("wrap_pc0", w_seen[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", w_seen[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", w_seen[2], 32'h0000_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
